// File: rtl/inst_fetch.sv
// inst_fetch: PC, single-outstanding req/ack fetch FSM and IF/ID FIFO.
// Define IF_FETCH_STAT_EN to add fetch_cnt_o / drop_cnt_o counters.
`timescale 1ns/1ps
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  output logic             inst_req_o,
  output logic [31:0]      inst_addr_o,
  input  logic             inst_ack_i,
  input  logic [31:0]      inst_data_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [31:0]      redirect_pc_i,
  output logic             if_valid_o,
  output logic [31:0]      if_pc_o,
  output logic [31:0]      if_inst_o,
  output logic [CNT_W-1:0] fifo_level_o
`ifdef IF_FETCH_STAT_EN
  ,
  output logic [31:0]      fetch_cnt_o,
  output logic [15:0]      drop_cnt_o
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  state_t           state, state_d;
  logic [31:0]      pc, pc_d;
  logic [31:0]      addr, addr_d;
  logic [CNT_W-1:0] level, level_d;
  logic [PW-1:0]    wptr, rptr;
  if_id_t           mem [FIFO_DEPTH];
  logic             hs, push, pop;

  assign hs   = inst_req_o && inst_ack_i;
  assign pop  = if_valid_o && !stall_i && !flush_i;
  assign push = hs && (state == REQ) && !flush_i;

  assign level_d = flush_i ? '0
                 : level + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    state_d = state;
    pc_d    = pc;
    if (flush_i)
      pc_d = redirect_pc_i;
    else if (push)
      pc_d = pc + 32'd4;
    unique case (state)
      IDLE: begin
        if (flush_i || level_d != FULL)
          state_d = REQ;
      end
      REQ: begin
        if (flush_i)
          state_d = hs ? REQ : DROP;
        else if (hs && level_d == FULL)
          state_d = IDLE;
      end
      DROP: begin
        if (hs)
          state_d = (level_d == FULL) ? IDLE : REQ;
      end
      default: state_d = IDLE;
    endcase
    // A stale request keeps its address until memory acks it.
    addr_d = (state_d == DROP) ? addr : pc_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      addr       <= RESET_PC;
      inst_req_o <= 1'b0;
      level      <= '0;
      wptr       <= '0;
      rptr       <= '0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      addr       <= addr_d;
      inst_req_o <= (state_d != IDLE);
      level      <= level_d;
      if (flush_i) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= '{pc: pc, inst: inst_data_i};
  end

  assign inst_addr_o  = addr;
  assign fifo_level_o = level;
  assign if_valid_o   = (level != '0);
  assign if_pc_o      = if_valid_o ? mem[rptr].pc   : '0;
  assign if_inst_o    = if_valid_o ? mem[rptr].inst : '0;

  a_no_push_full: assert property (
    @(posedge clk) disable iff (!rst)
    !(push && level == FULL)
  );

`ifdef IF_FETCH_STAT_EN
  logic discard;
  assign discard = hs && (flush_i || state == DROP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_o <= '0;
      drop_cnt_o  <= '0;
    end else begin
      if (push)    fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (discard) drop_cnt_o  <= drop_cnt_o + 16'd1;
    end
  end
`else
  // Statistics counters not built.
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed vectors for inst_fetch with a zero-wait memory.
// Memory word for address a is a ^ 32'h5A5A_00F0.
`timescale 1ns/1ps
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_ack_i = 1'b0;
  logic [31:0] inst_data_i = '0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic [2:0]  fifo_level_o;
`ifdef IF_FETCH_STAT_EN
  logic [31:0] fetch_cnt_o;
  logic [15:0] drop_cnt_o;
`endif

  int vec = 0;
  int err = 0;

  inst_fetch #(
    .RESET_PC  (32'h0),
    .FIFO_DEPTH(4),
    .CNT_W     (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req_o   (inst_req_o),
    .inst_addr_o  (inst_addr_o),
    .inst_ack_i   (inst_ack_i),
    .inst_data_i  (inst_data_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .redirect_pc_i(redirect_pc_i),
    .if_valid_o   (if_valid_o),
    .if_pc_o      (if_pc_o),
    .if_inst_o    (if_inst_o),
`ifdef IF_FETCH_STAT_EN
    .fetch_cnt_o  (fetch_cnt_o),
    .drop_cnt_o   (drop_cnt_o),
`endif
    .fifo_level_o (fifo_level_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mword(input logic [31:0] a);
    return a ^ 32'h5A5A_00F0;
  endfunction

  task automatic step(input bit en);
    @(negedge clk);
    inst_ack_i  = en && inst_req_o;
    inst_data_i = mword(inst_addr_o);
  endtask

  task automatic do_reset();
    flush_i    = 1'b0;
    stall_i    = 1'b0;
    inst_ack_i = 1'b0;
    rst        = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vec++;
    if (inst_req_o !== 1'b0) begin
      err++;
      $display("FAIL rst_req: got %b want 0", inst_req_o);
    end
    vec++;
    if (if_valid_o !== 1'b0) begin
      err++;
      $display("FAIL rst_valid: got %b want 0", if_valid_o);
    end
    vec++;
    if (if_pc_o !== 32'h0 || if_inst_o !== 32'h0) begin
      err++;
      $display("FAIL rst_head: got %h/%h want 0/0",
               if_pc_o, if_inst_o);
    end
    vec++;
    if (fifo_level_o !== 3'd0 || inst_addr_o !== 32'h0) begin
      err++;
      $display("FAIL rst_lvl_addr: got %0d/%h want 0/0",
               fifo_level_o, inst_addr_o);
    end
  endtask

  task automatic test_stream();
    do_reset();
    step(1);
    vec++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h0
        || if_valid_o !== 1'b0) begin
      err++;
      $display("FAIL s_first: got req=%b addr=%h v=%b want 1/0/0",
               inst_req_o, inst_addr_o, if_valid_o);
    end
    for (int k = 0; k < 6; k++) begin
      step(1);
      vec++;
      if (if_valid_o !== 1'b1 || if_pc_o !== 32'(4 * k)
          || if_inst_o !== mword(32'(4 * k))) begin
        err++;
        $display("FAIL s_head%0d: got v=%b pc=%h i=%h want 1/%h/%h",
                 k, if_valid_o, if_pc_o, if_inst_o,
                 32'(4 * k), mword(32'(4 * k)));
      end
      vec++;
      if (inst_addr_o !== 32'(4 * k + 4) || fifo_level_o !== 3'd1) begin
        err++;
        $display("FAIL s_addr%0d: got %h lvl=%0d want %h lvl=1",
                 k, inst_addr_o, fifo_level_o, 32'(4 * k + 4));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    stall_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      vec++;
      if (fifo_level_o !== 3'(i - 1) || inst_req_o !== 1'b1) begin
        err++;
        $display("FAIL st_fill%0d: got lvl=%0d req=%b want %0d/1",
                 i, fifo_level_o, inst_req_o, i - 1);
      end
    end
    step(1);
    step(1);
    vec++;
    if (fifo_level_o !== 3'd4 || inst_req_o !== 1'b0) begin
      err++;
      $display("FAIL st_full: got lvl=%0d req=%b want 4/0",
               fifo_level_o, inst_req_o);
    end
    vec++;
    if (if_pc_o !== 32'h0 || if_inst_o !== mword(32'h0)) begin
      err++;
      $display("FAIL st_head0: got %h/%h want 0/%h",
               if_pc_o, if_inst_o, mword(32'h0));
    end
    stall_i = 1'b0;
    step(1);
    vec++;
    if (fifo_level_o !== 3'd3 || inst_req_o !== 1'b1
        || inst_addr_o !== 32'h10) begin
      err++;
      $display("FAIL st_resume: got lvl=%0d req=%b addr=%h want 3/1/10",
               fifo_level_o, inst_req_o, inst_addr_o);
    end
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) step(1);
      vec++;
      if (if_pc_o !== 32'(4 * k) || if_inst_o !== mword(32'(4 * k))) begin
        err++;
        $display("FAIL st_pop%0d: got %h/%h want %h/%h",
                 k, if_pc_o, if_inst_o, 32'(4 * k), mword(32'(4 * k)));
      end
    end
  endtask

  task automatic test_flush_pending();
    do_reset();
    stall_i = 1'b1;
    step(1);
    step(1);
    step(0);
    vec++;
    if (fifo_level_o !== 3'd2 || inst_addr_o !== 32'h8) begin
      err++;
      $display("FAIL fp_pre: got lvl=%0d addr=%h want 2/8",
               fifo_level_o, inst_addr_o);
    end
    flush_i       = 1'b1;
    redirect_pc_i = 32'h0000_0100;
    stall_i       = 1'b0;
    step(0);
    flush_i = 1'b0;
    vec++;
    if (fifo_level_o !== 3'd0 || if_valid_o !== 1'b0) begin
      err++;
      $display("FAIL fp_empty: got lvl=%0d v=%b want 0/0",
               fifo_level_o, if_valid_o);
    end
    vec++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h8) begin
      err++;
      $display("FAIL fp_stale: got req=%b addr=%h want 1/8",
               inst_req_o, inst_addr_o);
    end
    step(0);
    step(0);
    inst_ack_i  = 1'b1;
    inst_data_i = 32'hDEAD_BEEF;
    step(0);
    vec++;
    if (if_valid_o !== 1'b0 || fifo_level_o !== 3'd0) begin
      err++;
      $display("FAIL fp_discard: got v=%b lvl=%0d want 0/0",
               if_valid_o, fifo_level_o);
    end
    vec++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h100) begin
      err++;
      $display("FAIL fp_redir: got req=%b addr=%h want 1/100",
               inst_req_o, inst_addr_o);
    end
    step(1);
    step(1);
    vec++;
    if (if_valid_o !== 1'b1 || if_pc_o !== 32'h100
        || if_inst_o !== mword(32'h100)) begin
      err++;
      $display("FAIL fp_new: got v=%b pc=%h i=%h want 1/100/%h",
               if_valid_o, if_pc_o, if_inst_o, mword(32'h100));
    end
  endtask

  task automatic test_flush_ack_pop();
    do_reset();
    step(1);
    step(1);
    vec++;
    if (if_valid_o !== 1'b1 || inst_ack_i !== 1'b1) begin
      err++;
      $display("FAIL fa_pre: got v=%b ack=%b want 1/1",
               if_valid_o, inst_ack_i);
    end
    flush_i       = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    step(1);
    flush_i = 1'b0;
    vec++;
    if (fifo_level_o !== 3'd0 || if_valid_o !== 1'b0) begin
      err++;
      $display("FAIL fa_nopush: got lvl=%0d v=%b want 0/0",
               fifo_level_o, if_valid_o);
    end
    vec++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h200) begin
      err++;
      $display("FAIL fa_addr: got req=%b addr=%h want 1/200",
               inst_req_o, inst_addr_o);
    end
    step(1);
    vec++;
    if (if_pc_o !== 32'h200 || fifo_level_o !== 3'd1
        || inst_addr_o !== 32'h204) begin
      err++;
      $display("FAIL fa_new: got pc=%h lvl=%0d addr=%h want 200/1/204",
               if_pc_o, fifo_level_o, inst_addr_o);
    end
  endtask

  task automatic test_wrap();
    flush_i       = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    step(1);
    flush_i = 1'b0;
    vec++;
    if (inst_addr_o !== 32'hFFFF_FFFC || fifo_level_o !== 3'd0) begin
      err++;
      $display("FAIL w_top: got addr=%h lvl=%0d want fffffffc/0",
               inst_addr_o, fifo_level_o);
    end
    step(1);
    vec++;
    if (inst_addr_o !== 32'h0 || if_pc_o !== 32'hFFFF_FFFC
        || if_inst_o !== mword(32'hFFFF_FFFC)) begin
      err++;
      $display("FAIL w_wrap: got addr=%h pc=%h i=%h want 0/fffffffc/%h",
               inst_addr_o, if_pc_o, if_inst_o, mword(32'hFFFF_FFFC));
    end
    step(1);
    vec++;
    if (if_pc_o !== 32'h0 || if_inst_o !== mword(32'h0)
        || fifo_level_o !== 3'd1) begin
      err++;
      $display("FAIL w_zero: got pc=%h i=%h lvl=%0d want 0/%h/1",
               if_pc_o, if_inst_o, fifo_level_o, mword(32'h0));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    stall_i = 1'b1;
    step(1);
    step(1);
    step(1);
    step(0);
    vec++;
    if (fifo_level_o !== 3'd3 || inst_req_o !== 1'b1) begin
      err++;
      $display("FAIL ar_pre: got lvl=%0d req=%b want 3/1",
               fifo_level_o, inst_req_o);
    end
    #2;
    rst = 1'b0;
    #1;
    vec++;
    if (inst_req_o !== 1'b0 || if_valid_o !== 1'b0
        || fifo_level_o !== 3'd0) begin
      err++;
      $display("FAIL ar_now: got req=%b v=%b lvl=%0d want 0/0/0",
               inst_req_o, if_valid_o, fifo_level_o);
    end
    vec++;
    if (if_pc_o !== 32'h0 || if_inst_o !== 32'h0
        || inst_addr_o !== 32'h0) begin
      err++;
      $display("FAIL ar_zero: got pc=%h i=%h addr=%h want 0/0/0",
               if_pc_o, if_inst_o, inst_addr_o);
    end
    @(negedge clk);
    stall_i = 1'b0;
    rst     = 1'b1;
    step(1);
    vec++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h0) begin
      err++;
      $display("FAIL ar_restart: got req=%b addr=%h want 1/0",
               inst_req_o, inst_addr_o);
    end
    step(1);
    vec++;
    if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0
        || if_inst_o !== mword(32'h0)) begin
      err++;
      $display("FAIL ar_first: got v=%b pc=%h i=%h want 1/0/%h",
               if_valid_o, if_pc_o, if_inst_o, mword(32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_pending();
    test_flush_ack_pop();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
